// File: rtl/rs_seg_addsub_pipe_if.sv
// rs_seg_addsub_pipe_if
// Operand and result streams of the segmented add/subtract pipeline.
//
// Handshake semantics, both sides: a beat transfers on a rising clock edge
// where valid && ready. The producer presents a beat and may hold it until
// it transfers. The unit's ready may depend combinationally on the
// consumer's ready (in_ready follows out_ready) but never on in_valid.
//
// Signals:
//   in_valid / in_ready   operand beat handshake
//   A, B                  operands (WIDTH bits)
//   SUB                   0: add, 1: subtract
//   CI                    carry-in (add) / borrow-in (subtract)
//   out_valid / out_ready result beat handshake
//   Y                     result (WIDTH bits)
//   CO                    carry out of bit WIDTH-1 (1 = no borrow on subtract)
//   OV                    signed overflow
// Modports: slave = the arithmetic unit, master = producer/consumer side.
interface rs_seg_addsub_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SUB;
  logic             CI;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic             CO;
  logic             OV;

  modport slave (
    input  in_valid, A, B, SUB, CI, out_ready,
    output in_ready, out_valid, Y, CO, OV
  );

  modport master (
    output in_valid, A, B, SUB, CI, out_ready,
    input  in_ready, out_valid, Y, CO, OV
  );
endinterface

// File: rtl/rs_seg_addsub_pipe.sv
// rs_seg_addsub_pipe
// Pipelined add/subtract. The WIDTH-bit carry chain is cut into NSEG
// segments of SEG bits (the last one may be narrower); segment k is added in
// stage k using the carry registered by stage k-1. Upper operand segments
// travel through skew registers and finished lower result segments through
// deskew registers, so the whole result leaves together after NSEG stages.
//
// Ports:
//   C      clock, rising edge
//   R      asynchronous active-low reset
//   flush  synchronous drop of every in-flight beat
//   bus    operand/result streams (rs_seg_addsub_pipe_if.slave)
module rs_seg_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input logic                C,
  input logic                R,
  input logic                flush,
  rs_seg_addsub_pipe_if.slave bus
);
  localparam int NSEG   = (WIDTH + SEG - 1) / SEG;
  localparam int LAST_W = WIDTH - (NSEG - 1) * SEG;

  function automatic int seg_w(input int k);
    return (k == NSEG - 1) ? LAST_W : SEG;
  endfunction

  // Stage k keeps result bits [k*SEG+seg_w(k)-1:0]; all stages' result
  // registers are packed end to end in res_q, this is where stage k starts.
  function automatic int res_off(input int k);
    int s;
    s = 0;
    for (int j = 0; j < k; j++) s += j * SEG + seg_w(j);
    return s;
  endfunction

  // Stage k (k < NSEG-1) keeps the operand bits above its segment; packed
  // end to end in opa_q/opb_q, this is where stage k starts.
  function automatic int op_off(input int k);
    int s;
    s = 0;
    for (int j = 0; j < k; j++) s += WIDTH - (j * SEG + seg_w(j));
    return s;
  endfunction

  localparam int RESW = res_off(NSEG);
  localparam int OPW  = (NSEG > 1) ? op_off(NSEG - 1) : 1;

  logic             en;
  logic             accept;
  logic [WIDTH-1:0] b_cond;
  logic             c_cond;

  logic [RESW-1:0]  res_q, res_d;
  logic [OPW-1:0]   opa_q, opa_d;
  logic [OPW-1:0]   opb_q, opb_d;
  logic [NSEG-1:0]  cy_q, cy_d;
  logic [NSEG-1:0]  v_q, v_in;
  logic             ov_q, ov_d;

  // One global enable: the whole pipe moves unless a result is stuck at the
  // output. Bubbles are carried along, not squeezed out.
  assign en           = !v_q[NSEG-1] || bus.out_ready;
  assign bus.in_ready = en && !flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // Subtract is A + ~B + ~CI, so a borrow-in becomes a missing carry-in.
  assign b_cond = bus.SUB ? ~bus.B  : bus.B;
  assign c_cond = bus.SUB ? ~bus.CI : bus.CI;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO = k * SEG;
    localparam int SW = seg_w(k);
    localparam int RW = LO + SW;
    localparam int OW = WIDTH - RW;
    localparam int RO = res_off(k);

    logic [SW-1:0] a_s, b_s;
    logic          c_s;
    logic [SW:0]   sum_s;

    if (k == 0) begin : g_head
      assign a_s                 = bus.A[SW-1:0];
      assign b_s                 = b_cond[SW-1:0];
      assign c_s                 = c_cond;
      assign v_in[k]             = accept;
      assign res_d[RO +: RW]     = sum_s[SW-1:0];
    end else begin : g_body
      localparam int PO  = op_off(k - 1);
      localparam int PRO = res_off(k - 1);
      assign a_s                 = opa_q[PO +: SW];
      assign b_s                 = opb_q[PO +: SW];
      assign c_s                 = cy_q[k-1];
      assign v_in[k]             = v_q[k-1];
      assign res_d[RO +: RW]     = {sum_s[SW-1:0], res_q[PRO +: LO]};
    end

    assign sum_s   = {1'b0, a_s} + {1'b0, b_s} + {{SW{1'b0}}, c_s};
    assign cy_d[k] = sum_s[SW];

    // Operand bits not yet consumed move one stage further up the skew.
    if (k < NSEG - 1) begin : g_skew
      localparam int OO = op_off(k);
      if (k == 0) begin : g_skew_head
        assign opa_d[OO +: OW] = bus.A[WIDTH-1:RW];
        assign opb_d[OO +: OW] = b_cond[WIDTH-1:RW];
      end else begin : g_skew_body
        localparam int PO = op_off(k - 1);
        assign opa_d[OO +: OW] = opa_q[PO + SW +: OW];
        assign opb_d[OO +: OW] = opb_q[PO + SW +: OW];
      end
    end

    // Carry into the MSB is recovered from the MSB sum bit of the last
    // segment, so overflow needs no extra chain.
    if (k == NSEG - 1) begin : g_tail
      logic msb_cin;
      assign msb_cin = a_s[SW-1] ^ b_s[SW-1] ^ sum_s[SW-1];
      assign ov_d    = msb_cin ^ sum_s[SW];
    end
  end

  if (NSEG == 1) begin : g_no_skew
    assign opa_d = '0;
    assign opb_d = '0;
  end

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      v_q   <= '0;
      cy_q  <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      // Flush drops valid bits even while stalled; data may stay stale.
      if (flush) begin
        v_q <= '0;
      end else if (en) begin
        v_q <= v_in;
      end
      if (en) begin
        res_q <= res_d;
        cy_q  <= cy_d;
        ov_q  <= ov_d;
        opa_q <= opa_d;
        opb_q <= opb_d;
      end
    end
  end

  assign bus.out_valid = v_q[NSEG-1];
  assign bus.Y         = res_q[RESW-1 -: WIDTH];
  assign bus.CO        = cy_q[NSEG-1];
  assign bus.OV        = ov_q;
endmodule
